lap_stopwatch: RTL and testbench

Parametrised BCD stopwatch with DIGITS decimal counters, a run/stop/lap state machine and a selectable DISP_DIGITS-wide window driving active-low 7-segment displays. Raw active-low push-buttons are synchronised and edge-detected internally. The block is the board-level timing top for DE-series boards and replaces the fixed 4-of-6-digit stopwatch.

---
 rtl/stopwatch_pkg.sv | 46 ++++
 rtl/key_edge_sync.sv | 39 +++
 rtl/lap_stopwatch.sv | 199 +++++++++++++++++++
 tb/tb_lap_stopwatch.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg - shared types and helpers for the lap_stopwatch block.
//
// Contents:
//   sw_state_t  - stopwatch control state (IDLE, RUN, STOP, LAP)
//   SEG_ZERO    - active-low gfedcba pattern for the digit "0"
//   SEG_BLANK   - pattern shown for any non-BCD code (segment g only)
//   calc_div    - prescaler divide ratio from clock and tick rates
//   bcd_to_seg  - BCD digit to active-low gfedcba segments
//
// Optional feature macro used by the block: LAP_STOPWATCH_SATURATE_EN.

package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } sw_state_t;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0111111;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/key_edge_sync.sv
// key_edge_sync - synchroniser and falling-edge detector for one raw
// active-low push-button. No debounce.
//
// Ports:
//   CLOCK_50  in   system clock
//   reset     in   synchronous, active-high; flops return to "released"
//   key_n     in   raw button, active-low, asynchronous to CLOCK_50
//   press     out  one-cycle pulse, 3 cycles after the raw 1->0 edge
//
// Optional feature macro (top level): LAP_STOPWATCH_SATURATE_EN (unused here).

module key_edge_sync (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    // press is registered so the pulse lands exactly 3 cycles after the
    // raw edge is first sampled; holding the key yields a single pulse.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_1    <= 1'b1;
            sync_2    <= 1'b1;
            sync_prev <= 1'b1;
            press     <= 1'b0;
        end else begin
            sync_1    <= key_n;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
            press     <= sync_prev & ~sync_2;
        end
    end

endmodule

// File: rtl/lap_stopwatch.sv
// lap_stopwatch - BCD stopwatch with run/stop/lap control and a selectable
// window of digits on active-low 7-segment displays.
//
// Parameters: CLK_HZ, TICK_HZ (CLK_HZ/TICK_HZ integer >= 2), DIGITS (>= 2),
//             DISP_DIGITS (<= DIGITS).
// Ports:
//   CLOCK_50     in   system clock
//   reset        in   synchronous, active-high; clears everything
//   key_start_n  in   raw start/stop button, active-low
//   key_lap_n    in   raw lap/clear button, active-low
//   win_sel      in   index of lowest displayed digit (clamped)
//   hex          out  7*DISP_DIGITS segments, active-low gfedcba,
//                     hex[6:0] is the rightmost digit (registered)
//   running      out  high in RUN and LAP
//   lap_frozen   out  high in LAP
//   overflow     out  sticky rollover flag, cleared by reset or clear
//
// Macro LAP_STOPWATCH_SATURATE_EN: when defined the counter holds at all-9s
// instead of wrapping to zero.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | cleared, not counting; lap ignored
// RUN   | counting, display shows live digits
// LAP   | counting, display shows captured lap_reg
// STOP  | frozen (prescaler too); lap clears and returns to IDLE

module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int TICK_HZ     = 100,
    parameter int DIGITS      = 6,
    parameter int DISP_DIGITS = 4,
    localparam int WSEL_W     = ((DIGITS - DISP_DIGITS + 1) > 1)
                                ? $clog2(DIGITS - DISP_DIGITS + 1) : 1
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     key_start_n,
    input  logic                     key_lap_n,
    input  logic [WSEL_W-1:0]        win_sel,
    output logic [7*DISP_DIGITS-1:0] hex,
    output logic                     running,
    output logic                     lap_frozen,
    output logic                     overflow
);

    localparam int DIV  = calc_div(CLK_HZ, TICK_HZ);
    localparam int PW   = $clog2(DIV);
    localparam int MAXW = DIGITS - DISP_DIGITS;
    localparam int DW   = 4 * DIGITS;

    sw_state_t               state;
    logic [PW-1:0]           presc;
    logic [DW-1:0]           digits;
    logic [DW-1:0]           digits_nxt;
    logic [DW-1:0]           lap_reg;
    logic [DIGITS:0]         carry;
    logic                    start_p;
    logic                    lap_p;
    logic                    counting;
    logic                    tick;
    logic                    clear;
    logic                    hold_sat;
    logic [DW-1:0]           disp_src;
    logic [WSEL_W-1:0]       win_eff;
    logic [7*DISP_DIGITS-1:0] hex_nxt;

    key_edge_sync u_key_start (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .key_n    (key_start_n),
        .press    (start_p)
    );

    key_edge_sync u_key_lap (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .key_n    (key_lap_n),
        .press    (lap_p)
    );

    assign counting = (state == RUN) || (state == LAP);
    assign tick     = counting && (presc == PW'(DIV - 1));
    // Start always wins over a simultaneous lap press.
    assign clear    = (state == STOP) && lap_p && !start_p;

    // Ripple carry: digit i advances when every lower digit is 9 on a tick.
    assign carry[0] = tick;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            logic [3:0] cur;
            assign cur          = digits[4*i +: 4];
            assign carry[i+1]   = carry[i] && (cur == 4'd9);
            assign digits_nxt[4*i +: 4] =
                clear                  ? 4'd0 :
                (carry[i] && !hold_sat) ? ((cur == 4'd9) ? 4'd0 : cur + 4'd1) :
                                          cur;
        end
    endgenerate

    // carry[DIGITS] marks the tick that would roll the whole chain over.
`ifdef LAP_STOPWATCH_SATURATE_EN
    assign hold_sat = carry[DIGITS];
`else
    assign hold_sat = 1'b0;
`endif

    assign disp_src = (state == LAP) ? lap_reg : digits;
    assign win_eff  = (win_sel > WSEL_W'(MAXW)) ? WSEL_W'(MAXW) : win_sel;

    generate
        for (genvar j = 0; j < DISP_DIGITS; j++) begin : g_win
            logic [3:0] code;
            always_comb begin
                code = 4'd0;
                for (int k = 0; k <= MAXW; k++) begin
                    if (win_eff == WSEL_W'(k)) begin
                        code = disp_src[4*(k+j) +: 4];
                    end
                end
            end
            assign hex_nxt[7*j +: 7] = bcd_to_seg(code);
        end
    endgenerate

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            presc      <= '0;
            digits     <= '0;
            lap_reg    <= '0;
            overflow   <= 1'b0;
            running    <= 1'b0;
            lap_frozen <= 1'b0;
            hex        <= {DISP_DIGITS{SEG_ZERO}};
        end else begin
            digits <= digits_nxt;
            hex    <= hex_nxt;

            // Prescaler only moves while counting, so a stop resumes mid-interval.
            if (clear) begin
                presc <= '0;
            end else if (counting) begin
                presc <= (presc == PW'(DIV - 1)) ? '0 : presc + 1'b1;
            end

            if (clear) begin
                overflow <= 1'b0;
            end else if (carry[DIGITS]) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_p) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (start_p) begin
                        state   <= STOP;
                        running <= 1'b0;
                    end else if (lap_p) begin
                        state      <= LAP;
                        lap_frozen <= 1'b1;
                        lap_reg    <= digits;
                    end
                end
                LAP: begin
                    if (start_p) begin
                        state      <= STOP;
                        running    <= 1'b0;
                        lap_frozen <= 1'b0;
                    end else if (lap_p) begin
                        lap_reg <= digits;
                    end
                end
                STOP: begin
                    if (start_p) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (lap_p) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    running    <= 1'b0;
                    lap_frozen <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lap_stopwatch.sv
// tb_lap_stopwatch - self-checking bench for lap_stopwatch with
// CLK_HZ=1000, TICK_HZ=100 (DIV=10), DIGITS=6, DISP_DIGITS=4.
// Honours LAP_STOPWATCH_SATURATE_EN in its model when defined.

module tb_lap_stopwatch;

    localparam int DIV    = 10;
    localparam int MAXVAL = 999999;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S9 = 7'b0010000;
    localparam logic [27:0] H0000 = {S0, S0, S0, S0};

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        key_start_n = 1'b1;
    logic        key_lap_n = 1'b1;
    logic [1:0]  win_sel = 2'd0;
    logic [27:0] hex;
    logic        running;
    logic        lap_frozen;
    logic        overflow;

    lap_stopwatch #(
        .CLK_HZ      (1000),
        .TICK_HZ     (100),
        .DIGITS      (6),
        .DISP_DIGITS (4)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .key_start_n (key_start_n),
        .key_lap_n   (key_lap_n),
        .win_sel     (win_sel),
        .hex         (hex),
        .running     (running),
        .lap_frozen  (lap_frozen),
        .overflow    (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_RUN, M_STOP, M_LAP} mode_t;

    logic [6:0] seg_tab [10];
    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
    end

    function automatic logic [27:0] show(input int value, input int win);
        logic [27:0] r;
        int w;
        int p;
        w = (win > 2) ? 2 : win;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            p = 1;
            for (int e = 0; e < w + j; e++) p = p * 10;
            r[7*j +: 7] = seg_tab[(value / p) % 10];
        end
        return r;
    endfunction

    mode_t       m_mode = M_IDLE;
    int          m_count = 0;
    int          m_lap = 0;
    int          m_phase = 0;
    bit          m_ovf = 1'b0;
    bit          m_valid = 1'b0;
    logic [27:0] m_hex = '0;
    bit [3:0]    s_hist = 4'hF;   // raw key samples, [0] newest
    bit [3:0]    l_hist = 4'hF;
    int          preload_val = 0;
    int          preload_seq = 0;
    int          seen_seq = 0;

    always @(posedge CLOCK_50) begin
        bit sp, lp, tk, live;
        int cap;
        if (reset) begin
            m_mode = M_IDLE; m_count = 0; m_lap = 0; m_phase = 0; m_ovf = 1'b0;
            s_hist = 4'hF; l_hist = 4'hF;
            m_hex = show(0, 0);
            m_valid = 1'b1;
            seen_seq = preload_seq;
        end else begin
            if (preload_seq != seen_seq) begin
                m_count  = preload_val;
                seen_seq = preload_seq;
            end
            // A raw press reaches the control logic 3 cycles after sampling.
            sp = s_hist[3] && !s_hist[2];
            lp = l_hist[3] && !l_hist[2];
            m_hex = show((m_mode == M_LAP) ? m_lap : m_count, int'(win_sel));
            live  = (m_mode == M_RUN) || (m_mode == M_LAP);
            tk    = live && (m_phase == DIV - 1);
            if (live) m_phase = (m_phase + 1) % DIV;
            cap = m_count;
            if (tk) begin
                if (m_count == MAXVAL) begin
                    m_ovf = 1'b1;
`ifdef LAP_STOPWATCH_SATURATE_EN
                    m_count = MAXVAL;
`else
                    m_count = 0;
`endif
                end else begin
                    m_count = m_count + 1;
                end
            end
            if (sp) begin
                case (m_mode)
                    M_IDLE, M_STOP: m_mode = M_RUN;
                    default:        m_mode = M_STOP;
                endcase
            end else if (lp) begin
                case (m_mode)
                    M_RUN:  begin m_mode = M_LAP; m_lap = cap; end
                    M_LAP:  m_lap = cap;
                    M_STOP: begin m_mode = M_IDLE; m_count = 0; m_phase = 0; m_ovf = 1'b0; end
                    default: ;
                endcase
            end
            s_hist = {s_hist[2:0], key_start_n};
            l_hist = {l_hist[2:0], key_lap_n};
        end
    end

    always @(negedge CLOCK_50) begin
        if (m_valid) begin
            check("running",    {31'd0, running},    {31'd0, (m_mode == M_RUN) || (m_mode == M_LAP)});
            check("lap_frozen", {31'd0, lap_frozen}, {31'd0, m_mode == M_LAP});
            check("overflow",   {31'd0, overflow},   {31'd0, m_ovf});
            check("hex",        {4'd0, hex},         {4'd0, m_hex});
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(input bit s, input bit l);
        @(negedge CLOCK_50);
        if (s) key_start_n = 1'b0;
        if (l) key_lap_n = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        key_start_n = 1'b1;
        key_lap_n   = 1'b1;
        repeat (3) @(negedge CLOCK_50);
    endtask

    task automatic wait_model(input int cnt, input string name);
        int n;
        n = 0;
        while (!(m_count == cnt && m_phase == 0) && n < 2000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(name, {31'd0, n < 2000}, 32'd1);
    endtask

    task automatic preload(input int val, input logic [23:0] bcd);
        @(negedge CLOCK_50);
        #2;
        force dut.digits = bcd;
        preload_val = val;
        preload_seq++;
        @(negedge CLOCK_50);
        release dut.digits;
        @(negedge CLOCK_50);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        check("reset_hex", {4'd0, hex}, {4'd0, H0000});

        // 1: start press latency and first 12 ticks
        @(negedge CLOCK_50);
        key_start_n = 1'b0;
        n = 0;
        while (!running && n < 20) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("start_latency", n, 4);
        @(negedge CLOCK_50);
        key_start_n = 1'b1;
        repeat (120) @(negedge CLOCK_50);
        check("hex_0012", {4'd0, hex}, {4'd0, S0, S0, S1, S2});
        check("model_count_12", m_count, 12);

        // 2: lap at 35, live reaches 50, then stop
        wait_model(35, "wait_35");
        press(1'b0, 1'b1);
        check("lap_frozen_set", {31'd0, lap_frozen}, 32'd1);
        check("lap_hex_0035", {4'd0, hex}, {4'd0, S0, S0, S3, S5});
        wait_model(50, "wait_50");
        check("lap_hold_0035", {4'd0, hex}, {4'd0, S0, S0, S3, S5});
        press(1'b1, 1'b0);
        check("stop_running", {31'd0, running}, 32'd0);
        check("stop_hex_0050", {4'd0, hex}, {4'd0, S0, S0, S5, S0});

        // 3: clear from STOP, lap in IDLE ignored
        press(1'b0, 1'b1);
        check("clear_hex", {4'd0, hex}, {4'd0, H0000});
        check("clear_ovf", {31'd0, overflow}, 32'd0);
        press(1'b0, 1'b1);
        check("idle_lap_running", {31'd0, running}, 32'd0);
        check("idle_lap_hex", {4'd0, hex}, {4'd0, H0000});

        // 4: rollover from all-9s
        preload(MAXVAL, 24'h999999);
        check("preload_9999", {4'd0, hex}, {4'd0, S9, S9, S9, S9});
        press(1'b1, 1'b0);
        n = 0;
        while (!overflow && n < 30) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("ovf_set", {31'd0, overflow}, 32'd1);
        @(negedge CLOCK_50);
`ifdef LAP_STOPWATCH_SATURATE_EN
        check("rollover_hex", {4'd0, hex}, {4'd0, S9, S9, S9, S9});
`else
        check("rollover_hex", {4'd0, hex}, {4'd0, H0000});
`endif
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // 5: display window and clamp
        preload(123456, 24'h123456);
        check("win0", {4'd0, hex}, {4'd0, S3, S4, S5, S6});
        win_sel = 2'd2;
        repeat (2) @(negedge CLOCK_50);
        check("win2", {4'd0, hex}, {4'd0, S1, S2, S3, S4});
        win_sel = 2'd3;
        repeat (2) @(negedge CLOCK_50);
        check("win3_clamped", {4'd0, hex}, {4'd0, S1, S2, S3, S4});
        win_sel = 2'd0;

        // 6: simultaneous start+lap in RUN, then reset mid-run
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        check("both_running", {31'd0, running}, 32'd0);
        check("both_no_lap", {31'd0, lap_frozen}, 32'd0);
        press(1'b1, 1'b0);
        repeat (5) @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        check("reset_run", {31'd0, running}, 32'd0);
        check("reset_hex_mid", {4'd0, hex}, {4'd0, H0000});
        repeat (3) @(negedge CLOCK_50);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
